// File: rtl/adler32_chk_pkg.sv
// Shared constants, state encoding and modular-reduction helpers for the
// Adler-32 checker and its byte-fold datapath.
package adler32_chk_pkg;

    localparam logic [18:0] MOD_BASE   = 19'd65521;
    localparam logic [18:0] MOD_BASE_2 = 19'd131042;
    localparam logic [18:0] MOD_BASE_3 = 19'd196563;
    localparam logic [18:0] MOD_BASE_4 = 19'd262084;
    localparam logic [31:0] ADLER_INIT = 32'h0000_0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_CMP  = 2'd3
    } state_t;

    // Input is at most 2*MOD_BASE-1, so a single conditional subtract is enough.
    function automatic logic [15:0] mod_once(input logic [18:0] v);
        logic [18:0] r;
        if (v >= MOD_BASE) begin
            r = v - MOD_BASE;
        end else begin
            r = v;
        end
        return r[15:0];
    endfunction

    // Input is at most 5*MOD_BASE-1; pick the largest k*MOD_BASE not above it.
    function automatic logic [15:0] mod_chain(input logic [18:0] v);
        logic [18:0] r;
        if (v >= MOD_BASE_4) begin
            r = v - MOD_BASE_4;
        end else if (v >= MOD_BASE_3) begin
            r = v - MOD_BASE_3;
        end else if (v >= MOD_BASE_2) begin
            r = v - MOD_BASE_2;
        end else if (v >= MOD_BASE) begin
            r = v - MOD_BASE;
        end else begin
            r = v;
        end
        return r[15:0];
    endfunction

endpackage

// File: rtl/adler32_chk_fold.sv
// Combinational fold of 1-4 bytes (MSB-first) into an Adler-32 {s1,s2} pair.
module adler32_fold
    import adler32_chk_pkg::*;
(
    input  logic [15:0] s1_i,
    input  logic [15:0] s2_i,
    input  logic [31:0] dat_i,
    input  logic [1:0]  num_i,
    output logic [15:0] s1_o,
    output logic [15:0] s2_o
);

    logic [18:0] s1_acc_s;
    logic [18:0] s2_acc_s;

    // Each partial s1 is reduced on the spot; s2 collects up to five reduced
    // terms (fits 19 bits) and is reduced once at the end.
    always_comb begin
        s1_acc_s = {3'b000, s1_i};
        s2_acc_s = {3'b000, s2_i};
        for (int k = 0; k < 4; k++) begin
            if (2'(k) <= num_i) begin
                s1_acc_s = {3'b000, mod_once(s1_acc_s + {11'd0, dat_i[31-8*k -: 8]})};
                s2_acc_s = s2_acc_s + s1_acc_s;
            end else begin
                s1_acc_s = s1_acc_s;
                s2_acc_s = s2_acc_s;
            end
        end
        s1_o = s1_acc_s[15:0];
        s2_o = mod_chain(s2_acc_s);
    end

endmodule

// File: rtl/adler32_chk.sv
// Receive-side Adler-32 checker: recomputes the checksum over inflated data
// and compares it with the zlib trailer value.
module adler32_chk
    import adler32_chk_pkg::*;
#(
    parameter int DATA_WD = 32,
    parameter int NUM_WD  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               val_i,
    input  logic [DATA_WD-1:0] dat_i,
    input  logic [NUM_WD-1:0]  num_i,
    input  logic               lst_i,
    input  logic               chk_val_i,
    input  logic [DATA_WD-1:0] chk_dat_i,
    output logic               done_o,
    output logic               val_o,
    output logic [DATA_WD-1:0] dat_o,
    output logic               err_o
);

    state_t             state_r;
    state_t             state_nx_s;
    logic [15:0]        s1_r;
    logic [15:0]        s2_r;
    logic [15:0]        s1_nx_s;
    logic [15:0]        s2_nx_s;
    logic [DATA_WD-1:0] chk_r;
    logic               chk_got_r;
    logic               lst_got_r;
    logic               done_nx_s;
    logic [DATA_WD-1:0] dat_nx_s;
    logic               err_nx_s;
    logic               accept_s;
    logic               chk_take_s;

    adler32_fold u_fold (
        .s1_i  (s1_r),
        .s2_i  (s2_r),
        .dat_i (dat_i),
        .num_i (num_i),
        .s1_o  (s1_nx_s),
        .s2_o  (s2_nx_s)
    );

    assign accept_s   = (state_r == ST_RUN) && val_i && !start_i;
    assign chk_take_s = ((state_r == ST_RUN) || (state_r == ST_WAIT)) && chk_val_i && !start_i;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; start_i aborts any stream and restarts in RUN.
    always_comb begin
        state_nx_s = state_r;
        if (start_i) begin
            state_nx_s = ST_RUN;
        end else begin
            case (state_r)
                ST_IDLE: state_nx_s = ST_IDLE;
                ST_RUN: begin
                    if (val_i && lst_i) begin
                        state_nx_s = ST_WAIT;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end
                ST_WAIT: begin
                    if (lst_got_r && chk_got_r) begin
                        state_nx_s = ST_CMP;
                    end else begin
                        state_nx_s = ST_WAIT;
                    end
                end
                ST_CMP:  state_nx_s = ST_IDLE;
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // Output next-values; the verdict is suppressed when start_i aborts CMP.
    always_comb begin
        done_nx_s = 1'b0;
        dat_nx_s  = dat_o;
        err_nx_s  = err_o;
        if (start_i) begin
            dat_nx_s = {DATA_WD{1'b0}};
            err_nx_s = 1'b0;
        end else if (state_r == ST_CMP) begin
            done_nx_s = 1'b1;
            dat_nx_s  = {s2_r, s1_r};
            err_nx_s  = ({s2_r, s1_r} != chk_r);
        end else begin
            done_nx_s = 1'b0;
        end
    end

    // Running sums, captured trailer value and arrival flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r      <= ADLER_INIT[15:0];
            s2_r      <= ADLER_INIT[31:16];
            chk_r     <= {DATA_WD{1'b0}};
            chk_got_r <= 1'b0;
            lst_got_r <= 1'b0;
        end else if (start_i) begin
            s1_r      <= ADLER_INIT[15:0];
            s2_r      <= ADLER_INIT[31:16];
            chk_r     <= {DATA_WD{1'b0}};
            chk_got_r <= 1'b0;
            lst_got_r <= 1'b0;
        end else begin
            if (accept_s) begin
                s1_r <= s1_nx_s;
                s2_r <= s2_nx_s;
                if (lst_i) begin
                    lst_got_r <= 1'b1;
                end
            end
            if (chk_take_s) begin
                chk_r     <= chk_dat_i;
                chk_got_r <= 1'b1;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_o <= 1'b0;
            val_o  <= 1'b0;
            dat_o  <= {DATA_WD{1'b0}};
            err_o  <= 1'b0;
        end else begin
            done_o <= done_nx_s;
            val_o  <= done_nx_s;
            dat_o  <= dat_nx_s;
            err_o  <= err_nx_s;
        end
    end

endmodule

// File: tb/tb_adler32_chk.sv
// Directed self-checking bench for adler32_chk with hand-computed checksums.
module tb_adler32_chk;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        val_i;
    logic [31:0] dat_i;
    logic [1:0]  num_i;
    logic        lst_i;
    logic        chk_val_i;
    logic [31:0] chk_dat_i;
    logic        done_o;
    logic        val_o;
    logic [31:0] dat_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    adler32_chk #(.DATA_WD(32), .NUM_WD(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .val_i     (val_i),
        .dat_i     (dat_i),
        .num_i     (num_i),
        .lst_i     (lst_i),
        .chk_val_i (chk_val_i),
        .chk_dat_i (chk_dat_i),
        .done_o    (done_o),
        .val_o     (val_o),
        .dat_o     (dat_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        rst = 1'b0; start_i = 1'b0; val_i = 1'b0; dat_i = 32'h0;
        num_i = 2'd0; lst_i = 1'b0; chk_val_i = 1'b0; chk_dat_i = 32'h0;
    endtask

    // Drive one cycle of inputs, let the edge take them, then return to idle.
    task automatic apply(input logic st, input logic v, input logic [31:0] d,
                         input logic [1:0] n, input logic l,
                         input logic cv, input logic [31:0] cd);
        start_i = st; val_i = v; dat_i = d; num_i = n; lst_i = l;
        chk_val_i = cv; chk_dat_i = cd;
        tick();
        clear_in();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Called right after the edge that accepted the later event.
    task automatic expect_verdict(input string tag, input logic [31:0] d, input logic e);
        idle(1);
        check({tag, " done early"}, {31'd0, done_o}, 32'd0);
        idle(1);
        check({tag, " done"}, {31'd0, done_o}, 32'd1);
        check({tag, " val"}, {31'd0, val_o}, 32'd1);
        check({tag, " dat"}, dat_o, d);
        check({tag, " err"}, {31'd0, err_o}, {31'd0, e});
        idle(1);
        check({tag, " done width"}, {31'd0, done_o}, 32'd0);
        check({tag, " dat held"}, dat_o, d);
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        check("reset done", {31'd0, done_o}, 32'd0);
        check("reset val", {31'd0, val_o}, 32'd0);
        check("reset dat", dat_o, 32'h0);
        check("reset err", {31'd0, err_o}, 32'd0);

        // "a": data then trailer one cycle later.
        apply(1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
        apply(1'b0, 1'b1, 32'h61000000, 2'd0, 1'b1, 1'b0, 32'h0);
        apply(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 32'h00620062);
        expect_verdict("a", 32'h00620062, 1'b0);

        // "abc": trailer before the data.
        apply(1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
        check("start clears dat", dat_o, 32'h0);
        apply(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 32'h024D0127);
        apply(1'b0, 1'b1, 32'h61626300, 2'd2, 1'b1, 1'b0, 32'h0);
        expect_verdict("abc", 32'h024D0127, 1'b0);

        // "Wikipedia": trailer 5 clk after the last word.
        apply(1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
        apply(1'b0, 1'b1, 32'h57696B69, 2'd3, 1'b0, 1'b0, 32'h0);
        apply(1'b0, 1'b1, 32'h70656469, 2'd3, 1'b0, 1'b0, 32'h0);
        apply(1'b0, 1'b1, 32'h61000000, 2'd0, 1'b1, 1'b0, 32'h0);
        idle(4);
        check("wiki no done before chk", {31'd0, done_o}, 32'd0);
        apply(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 32'h11E60398);
        expect_verdict("wiki", 32'h11E60398, 1'b0);

        // Modulo wrap: 1040 bytes of 0xFF, trailer with the last word.
        apply(1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 260; i++)
            apply(1'b0, 1'b1, 32'hFFFFFFFF, 2'd3, (i == 259), (i == 259), 32'hC4EE0C2D);
        expect_verdict("wrap ok", 32'hC4EE0C2D, 1'b0);

        apply(1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 260; i++)
            apply(1'b0, 1'b1, 32'hFFFFFFFF, 2'd3, (i == 259), (i == 259), 32'hC4EE0C2E);
        expect_verdict("wrap bad", 32'hC4EE0C2D, 1'b1);

        // Reset while outputs are non-zero.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst dat", dat_o, 32'h0);
        check("rst err", {31'd0, err_o}, 32'd0);
        check("rst done", {31'd0, done_o}, 32'd0);

        // Abort: restart with a same-cycle word that must be dropped.
        apply(1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
        apply(1'b0, 1'b1, 32'h11223344, 2'd3, 1'b0, 1'b0, 32'h0);
        apply(1'b0, 1'b1, 32'h55667788, 2'd3, 1'b0, 1'b0, 32'h0);
        apply(1'b1, 1'b1, 32'hFFFFFFFF, 2'd3, 1'b0, 1'b1, 32'h12345678);
        check("abort no done", {31'd0, done_o}, 32'd0);
        apply(1'b0, 1'b1, 32'h61626300, 2'd2, 1'b1, 1'b1, 32'h024D0127);
        expect_verdict("abort", 32'h024D0127, 1'b0);
        idle(2);
        check("abort single done", {31'd0, done_o}, 32'd0);

        // Reset with a verdict pending: no done may follow.
        apply(1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
        apply(1'b0, 1'b1, 32'h61000000, 2'd0, 1'b1, 1'b1, 32'h00620062);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid rst dat", dat_o, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid rst no done", {31'd0, done_o}, 32'd0);
        end

        // Idle traffic is ignored.
        apply(1'b0, 1'b1, 32'h61000000, 2'd0, 1'b1, 1'b1, 32'h00620062);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle no done", {31'd0, done_o}, 32'd0);
        end
        check("idle dat", dat_o, 32'h0);

        // Normal stream still works afterwards; both events in one cycle.
        apply(1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
        apply(1'b0, 1'b1, 32'h61000000, 2'd0, 1'b1, 1'b1, 32'h00620063);
        expect_verdict("a mismatch", 32'h00620062, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
